// File: rtl/ca_seed_loader.sv
// ============================================================================
// Module      : ca_seed_loader
// Description : Fills a cellular-automaton seed row word by word, then runs
//               the CA for run_len generations and freezes the result.
//               Optional build macro: CA_SEED_LOADER_AUTORUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ca_seed_loader #(
    parameter int LEN = 512,
    parameter int W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    input  logic           start,
    input  logic           clear,
    input  logic [15:0]    run_len,
    input  logic [LEN-1:0] ca_q,
    output logic           load,
    output logic [LEN-1:0] data,
    output logic           busy,
    output logic           done,
    output logic [15:0]    gen_count
);

    localparam int c_NWORDS = LEN / W;
    localparam int c_CW     = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam logic [c_CW-1:0] c_LAST_WORD = c_CW'(c_NWORDS - 1);

    localparam logic [1:0] c_FILL  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_word_cnt;
    logic [LEN-1:0]  r_seed;
    logic [15:0]     r_run_len;
    logic [15:0]     r_gen_count;
    logic            r_done;

    logic w_accept;
    logic w_last_word;
    logic w_last_gen;
    logic w_run_nz;
    logic w_arm_go;
    logic w_enter_run;

    assign w_accept    = in_ready & in_valid;
    assign w_last_word = (r_word_cnt == c_LAST_WORD);
    assign w_last_gen  = ((r_gen_count + 16'd1) == r_run_len);
    assign w_run_nz    = |run_len;
    assign w_enter_run = (r_state != c_RUN) && (w_next_state == c_RUN);

`ifdef CA_SEED_LOADER_AUTORUN_EN
    assign w_arm_go = 1'b1;
`else
    assign w_arm_go = start;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear overrides every other transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FILL:  if (w_accept && w_last_word) w_next_state = c_ARMED;
            c_ARMED: if (w_arm_go) w_next_state = w_run_nz ? c_RUN : c_DONE;
            c_RUN:   if (w_last_gen) w_next_state = c_DONE;
            c_DONE:  if (start && w_run_nz) w_next_state = c_RUN;
            default: w_next_state = c_FILL;
        endcase
        if (clear) begin
            w_next_state = c_FILL;
        end
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        load     = 1'b1;
        busy     = 1'b0;
        data     = ca_q;
        case (r_state)
            c_FILL:  in_ready = 1'b1;
            c_ARMED: data = r_seed;
            c_RUN: begin
                load = 1'b0;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_word_cnt <= '0;
            r_seed     <= '0;
        end else if (w_accept) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
            for (int k = 0; k < c_NWORDS; k++) begin
                if (r_word_cnt == c_CW'(k)) begin
                    r_seed[k*W +: W] <= in_data;
                end
            end
        end
    end

    // Run length is captured on RUN entry; a zero-length launch still resets the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_len   <= '0;
            r_gen_count <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_enter_run) begin
                r_run_len <= run_len;
            end
            if (w_enter_run || (r_state == c_ARMED && w_next_state == c_DONE)) begin
                r_gen_count <= '0;
            end else if (r_state == c_RUN) begin
                r_gen_count <= r_gen_count + 16'd1;
            end
            r_done <= (w_next_state == c_DONE) && (r_state != c_DONE);
        end
    end

    assign done      = r_done;
    assign gen_count = r_gen_count;

endmodule

`default_nettype wire

// File: tb/tb_ca_seed_loader.sv
// ============================================================================
// Module      : tb_ca_seed_loader
// Description : Directed bench for ca_seed_loader (LEN=16, W=8) driving a
//               rule-110 CA stage with zero boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ca_seed_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        clear;
    logic [15:0] run_len;
    logic [15:0] ca_q = 16'h0000;
    logic        load;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    logic        cnt_clr;
    int          busy_cnt;
    int          done_cnt;
    int          n_checks = 0;
    int          n_err    = 0;

    ca_seed_loader #(.LEN(16), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .clear     (clear),
        .run_len   (run_len),
        .ca_q      (ca_q),
        .load      (load),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rule110(input logic [15:0] s);
        logic [15:0] l;
        logic [15:0] r;
        l = {1'b0, s[15:1]};
        r = {s[14:0], 1'b0};
        return (s & ~l) | (s ^ r);
    endfunction

    // CA stage under control of the loader
    always @(posedge clk) begin
        ca_q <= load ? data : rule110(ca_q);
    end

    always @(posedge clk) begin
        if (cnt_clr) begin
            busy_cnt <= 0;
            done_cnt <= 0;
        end else begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        clear = 1'b0; run_len = 16'd0; cnt_clr = 1'b1;
        step(); step();
        reset = 1'b0; start = 1'b1; run_len = 16'd3;
        step();
        start = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_load", load, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_data", data, 16'h0000);

        // Seed fill 0x01, 0x00
        in_valid = 1'b1; in_data = 8'h01;
        step();
        chk("fill_w0_ready", in_ready, 1);
        in_data = 8'h00;
        step();
        in_data = 8'hFF;
        chk("armed_ready", in_ready, 0);
        chk("armed_load", load, 1);
        chk("armed_data", data, 16'h0001);
        step();
        in_valid = 1'b0;
        chk("armed_ignore_word", data, 16'h0001);
        chk("armed_wait_busy", busy, 0);
        chk("armed_ca_held", ca_q, 16'h0001);

        // Run 4 generations
        cnt_clr = 1'b0; start = 1'b1; run_len = 16'd4;
        step();
        start = 1'b0; run_len = 16'd0;
        chk("run4_busy", busy, 1);
        chk("run4_gc_start", gen_count, 0);
        chk("run4_load", load, 0);
        for (int i = 0; i < 20 && done !== 1'b1; i++) step();
        chk("run4_done", done, 1);
        chk("run4_gc", gen_count, 4);
        chk("run4_ca", ca_q, 16'h001F);
        chk("run4_busy_end", busy, 0);
        step();
        chk("run4_done_pulse", done, 0);
        chk("run4_ca_frozen", ca_q, 16'h001F);
        chk("run4_busy_cycles", busy_cnt, 4);
        chk("run4_done_cnt", done_cnt, 1);
        chk("run4_gc_hold", gen_count, 4);

        // Continue one generation from DONE
        start = 1'b1; run_len = 16'd1;
        step();
        start = 1'b0;
        chk("run1_busy", busy, 1);
        step();
        chk("run1_done", done, 1);
        chk("run1_gc", gen_count, 1);
        chk("run1_ca", ca_q, 16'h0031);
        step();
        chk("run1_ca_frozen", ca_q, 16'h0031);
        chk("run1_load", load, 1);

        // Clear, refill with a gap, zero-length launch
        cnt_clr = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; cnt_clr = 1'b0;
        chk("clr_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 8'h01;
        step();
        in_valid = 1'b0; in_data = 8'hAA;
        step();
        in_valid = 1'b1; in_data = 8'h00;
        step();
        in_valid = 1'b0;
        chk("gap_armed_data", data, 16'h0001);
        chk("gap_armed_ready", in_ready, 0);
        start = 1'b1; run_len = 16'd0;
        step();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_gc", gen_count, 0);
        step();
        chk("zero_ca", ca_q, 16'h0001);
        chk("zero_done_pulse", done, 0);
        chk("zero_busy_cycles", busy_cnt, 0);
        chk("zero_done_cnt", done_cnt, 1);

        // Clear together with start in the second RUN cycle
        start = 1'b1; run_len = 16'd4;
        step();
        start = 1'b0;
        step();
        clear = 1'b1; start = 1'b1; run_len = 16'd4;
        step();
        clear = 1'b0; start = 1'b0;
        chk("clr_run_ready", in_ready, 1);
        chk("clr_run_load", load, 1);
        chk("clr_run_busy", busy, 0);
        chk("clr_run_seed", dut.r_seed, 16'h0000);

        // in_valid held with a one-cycle gap
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0; in_data = 8'hFF;
        step();
        in_valid = 1'b1; in_data = 8'hC3;
        step();
        in_data = 8'h77;
        chk("hold_gap_data", data, 16'hC35A);
        step();
        in_valid = 1'b0;
        chk("hold_gap_ignore", data, 16'hC35A);

        // Reset in the middle of a run
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b1; in_data = 8'h01;
        step();
        in_data = 8'h00;
        step();
        in_valid = 1'b0;
        start = 1'b1; run_len = 16'd5;
        step();
        start = 1'b0;
        step();
        chk("mid_busy", busy, 1);
        chk("mid_gc", gen_count, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_gc", gen_count, 0);
        chk("mid_rst_load", load, 1);
        chk("mid_rst_ca", ca_q, 16'h0007);
        step();
        chk("mid_rst_ca_frozen", ca_q, 16'h0007);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ca_seed_loader.md
CA_SEED_LOADER -- requirements
Module: ca_seed_loader

Interface
REQ-001 The block SHALL have parameter LEN, default 512: CA row width in cells; SHALL be a multiple of W.
REQ-002 The block SHALL have parameter W, default 8: seed input word width.
REQ-003 Port clk SHALL be input, width 1: single clock, all state on posedge.
REQ-004 Port reset SHALL be input, width 1: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be input, width 1: seed word valid.
REQ-006 Port in_data SHALL be input, width W: seed word.
REQ-007 Port in_ready SHALL be output, width 1: seed word accepted when in_valid & in_ready.
REQ-008 Port start SHALL be input, width 1: launch run.
REQ-009 Port clear SHALL be input, width 1: abort and return to seed fill.
REQ-010 Port run_len SHALL be input, width 16: number of generations to run, sampled on start.
REQ-011 Port ca_q SHALL be input, width LEN: current row fed back from the CA stage.
REQ-012 Port load SHALL be output, width 1: CA load strobe.
REQ-013 Port data SHALL be output, width LEN: CA load value.
REQ-014 Port busy SHALL be output, width 1: high in RUN.
REQ-015 Port done SHALL be output, width 1: one-cycle pulse on entry to DONE.
REQ-016 Port gen_count SHALL be output, width 16: generations executed in the current or last run.

Function
REQ-017 States SHALL be FILL, ARMED, RUN and DONE.
REQ-018 FILL: in_ready=1, load=1, data=ca_q (CA frozen); accepted word k (k = 0..LEN/W-1) SHALL be written to seed bits [k*W+W-1:k*W]; after word LEN/W-1 is accepted, go to ARMED next cycle.
REQ-019 ARMED: in_ready=0, load=1, data=seed (CA held at seed); start with run_len!=0 goes to RUN and latches run_len; start with run_len=0 goes to DONE.
REQ-020 RUN: load=0 for exactly the latched run_len consecutive cycles, so the CA advances exactly run_len generations; gen_count SHALL clear on RUN entry and increment by 1 each RUN cycle; after the run_len-th RUN cycle, go to DONE.
REQ-021 DONE: load=1, data=ca_q (result frozen); start with run_len!=0 goes to RUN again, continuing from the frozen row; gen_count SHALL hold its final value.
REQ-022 done SHALL be high exactly in the first cycle of DONE; busy SHALL equal (state==RUN).
REQ-023 data SHALL be a combinational mux of seed and ca_q selected by state, with no added register latency.
REQ-024 in_valid outside FILL SHALL be ignored; start in FILL or RUN SHALL be ignored.
REQ-025 clear in any state SHALL go to FILL next cycle, reset the word counter and zero the seed; clear SHALL win over simultaneous start or an accepted word.
REQ-026 gen_count SHALL NOT wrap, since run_len<=65535.

Reset
REQ-027 reset SHALL take priority over all inputs.
REQ-028 After reset: state=FILL, word counter=0, seed=0, gen_count=0, done=0, busy=0, in_ready=1, load=1, data=ca_q.
REQ-029 reset mid-RUN SHALL stop the run within the same edge; the CA SHALL be frozen at its current row from the next cycle.

Configuration
REQ-030 With macro CA_SEED_LOADER_AUTORUN_EN defined, ARMED SHALL last exactly one cycle and then behave as if start were asserted with the current run_len; start in ARMED is then redundant.
REQ-031 Without CA_SEED_LOADER_AUTORUN_EN, ARMED SHALL wait indefinitely for start.

Verification (LEN=16, W=8, driving a rule-110 CA stage with ca_q fed back)
REQ-032 Reset, then send words 0x01, 0x00 -> in_ready drops after the 2nd accept; ARMED data=0x0001, load=1.
REQ-033 start with run_len=4 -> busy high for 4 cycles; done pulses once; CA frozen at 0x001F; gen_count=4.
REQ-034 From DONE, start with run_len=1 -> CA advances one generation from 0x001F and freezes; gen_count=1.
REQ-035 start with run_len=0 in ARMED -> DONE next cycle, done pulse, CA held at 0x0001, busy never high.
REQ-036 clear asserted in the 2nd RUN cycle, together with start -> FILL next cycle, in_ready=1, load=1, seed=0.
REQ-037 in_valid held with a 1-cycle gap between words -> only valid&ready cycles are captured; seed matches the sent words.
